// File: rtl/mu0_core.sv
// Multi-cycle MU0 core: FETCH/EXEC sequencer driving a 16-bit word memory bus (memRq/readNotWrite).
// Optional single-step mode (WAIT state before every FETCH, `step` input) enabled by MU0_SINGLE_STEP_EN.
module mu0_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MU0_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        memRq,
  output logic        readNotWrite,
  output logic [15:0] addr,
  output logic [15:0] dataOut,
  input  logic [15:0] dataIn,
  output logic        halted,
  output logic [15:0] pc_dbg,
  output logic [15:0] acc_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
`ifdef MU0_SINGLE_STEP_EN
    ST_WAIT  = 3'd4,
`endif
    ST_HALT  = 3'd3
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  // Where the sequencer goes before each fetch: straight in, or parked until a step pulse.
`ifdef MU0_SINGLE_STEP_EN
  localparam state_t ST_PRE_FETCH = ST_WAIT;
`else
  localparam state_t ST_PRE_FETCH = ST_FETCH;
`endif

  state_t      state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] acc_r, acc_s;
  logic [15:0] ir_r, ir_s;
  logic [15:0] s_addr_s;
  logic        mem_rq_s, rnw_s, halted_s;
  logic [15:0] addr_s, data_out_s;

  assign s_addr_s = {4'h0, ir_r[11:0]};

`ifdef MU0_SINGLE_STEP_EN
  logic step_r;
  logic step_rise_s;

  // Previous value of step, for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_r <= 1'b0;
    end else begin
      step_r <= step;
    end
  end

  assign step_rise_s = step & ~step_r;
`endif

  // Next-state, datapath update and Moore bus decode from state/IR.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    acc_s      = acc_r;
    ir_s       = ir_r;
    mem_rq_s   = 1'b0;
    rnw_s      = 1'b1;
    addr_s     = 16'h0000;
    data_out_s = 16'h0000;
    halted_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_PRE_FETCH;
      end
`ifdef MU0_SINGLE_STEP_EN
      ST_WAIT: begin
        if (step_rise_s) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_WAIT;
        end
      end
`endif
      ST_FETCH: begin
        mem_rq_s = 1'b1;
        addr_s   = pc_r;
        ir_s     = dataIn;
        pc_s     = pc_r + 16'h0001;
        state_s  = ST_EXEC;
      end
      ST_EXEC: begin
        state_s = ST_PRE_FETCH;
        case (ir_r[15:12])
          OP_LDA: begin
            mem_rq_s = 1'b1;
            addr_s   = s_addr_s;
            acc_s    = dataIn;
          end
          OP_STO: begin
            mem_rq_s   = 1'b1;
            rnw_s      = 1'b0;
            addr_s     = s_addr_s;
            data_out_s = acc_r;
          end
          OP_ADD: begin
            mem_rq_s = 1'b1;
            addr_s   = s_addr_s;
            acc_s    = acc_r + dataIn;
          end
          OP_SUB: begin
            mem_rq_s = 1'b1;
            addr_s   = s_addr_s;
            acc_s    = acc_r - dataIn;
          end
          OP_JMP: begin
            pc_s = s_addr_s;
          end
          OP_JGE: begin
            if (!acc_r[15]) begin
              pc_s = s_addr_s;
            end else begin
              pc_s = pc_r;
            end
          end
          OP_JNE: begin
            if (acc_r != 16'h0000) begin
              pc_s = s_addr_s;
            end else begin
              pc_s = pc_r;
            end
          end
          OP_STP: begin
            state_s = ST_HALT;
          end
          default: begin
            state_s = ST_PRE_FETCH;
          end
        endcase
      end
      ST_HALT: begin
        halted_s = 1'b1;
        state_s  = ST_HALT;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Architectural registers; reset drops the bus asynchronously via state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      acc_r   <= 16'h0000;
      ir_r    <= 16'h0000;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      acc_r   <= acc_s;
      ir_r    <= ir_s;
    end
  end

  assign memRq        = mem_rq_s;
  assign readNotWrite = rnw_s;
  assign addr         = addr_s;
  assign dataOut      = data_out_s;
  assign halted       = halted_s;
  assign pc_dbg       = pc_r;
  assign acc_dbg      = acc_r;

endmodule

// File: tb/tb_mu0_core.sv
// Bench for mu0_core: directed programs plus random programs checked against an
// instruction-level MU0 interpreter; memory is a plain array answering the bus.
module tb_mu0_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memRq, readNotWrite, halted;
  logic [15:0] addr, dataOut, dataIn, pc_dbg, acc_dbg;
`ifdef MU0_SINGLE_STEP_EN
  logic        step;
`endif

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] m_pc, m_acc;
  logic        m_halt;
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  r_op;
  logic [11:0] r_s;

  always #5 clk = ~clk;

  assign dataIn = mem[addr];

  mu0_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef MU0_SINGLE_STEP_EN
    .step         (step),
`endif
    .memRq        (memRq),
    .readNotWrite (readNotWrite),
    .addr         (addr),
    .dataOut      (dataOut),
    .dataIn       (dataIn),
    .halted       (halted),
    .pc_dbg       (pc_dbg),
    .acc_dbg      (acc_dbg)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
  endtask

  task automatic load(input int a, input logic [15:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // Asynchronous reset from any point; leaves the bench at the negedge of the first post-reset state.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_pc   = 16'h0000;
    m_acc  = 16'h0000;
    m_halt = 1'b0;
    chk1("rst_memRq", memRq, 1'b0);
    chk1("rst_rnw", readNotWrite, 1'b1);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_dataOut", dataOut, 16'h0000);
    chk1("rst_halted", halted, 1'b0);
    chk("rst_pc", pc_dbg, 16'h0000);
    chk("rst_acc", acc_dbg, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One instruction, checked cycle by cycle against the interpreter state.
  task automatic run_instr();
    logic [15:0] ir, s, wa, wd;
    logic [3:0]  op;
    logic        exp_rq, exp_rnw, do_wr;
    logic [15:0] exp_do;
    if (m_halt) begin
      chk1("halt_halted", halted, 1'b1);
      chk1("halt_memRq", memRq, 1'b0);
      chk("halt_pc", pc_dbg, m_pc);
      chk("halt_acc", acc_dbg, m_acc);
      @(negedge clk);
      return;
    end
`ifdef MU0_SINGLE_STEP_EN
    repeat (2) begin
      chk1("wait_memRq", memRq, 1'b0);
      @(negedge clk);
    end
    chk1("wait_memRq", memRq, 1'b0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
`endif
    chk1("fetch_memRq", memRq, 1'b1);
    chk1("fetch_rnw", readNotWrite, 1'b1);
    chk("fetch_addr", addr, m_pc);
    chk("fetch_dataOut", dataOut, 16'h0000);
    chk("pc", pc_dbg, m_pc);
    chk("acc", acc_dbg, m_acc);
    chk1("halted", halted, 1'b0);
    ir   = ref_mem[m_pc];
    m_pc = m_pc + 16'h0001;
    op   = ir[15:12];
    s    = {4'h0, ir[11:0]};
    @(negedge clk);
    exp_rq  = (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'h3);
    exp_rnw = (op != 4'h1);
    exp_do  = (op == 4'h1) ? m_acc : 16'h0000;
    chk1("exec_memRq", memRq, exp_rq);
    chk1("exec_rnw", readNotWrite, exp_rnw);
    chk("exec_dataOut", dataOut, exp_do);
    if (exp_rq) chk("exec_addr", addr, s);
    do_wr = (memRq === 1'b1) && (readNotWrite === 1'b0);
    wa    = addr;
    wd    = dataOut;
    case (op)
      4'h0: m_acc = ref_mem[s];
      4'h1: ref_mem[s] = m_acc;
      4'h2: m_acc = m_acc + ref_mem[s];
      4'h3: m_acc = m_acc - ref_mem[s];
      4'h4: m_pc = s;
      4'h5: if (!m_acc[15]) m_pc = s;
      4'h6: if (m_acc != 16'h0000) m_pc = s;
      4'h7: m_halt = 1'b1;
      default: ;
    endcase
    @(negedge clk);
    if (do_wr) mem[wa] = wd;
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef MU0_SINGLE_STEP_EN
    step = 1'b0;
`endif
    // Reset values and first fetch at address 0.
    clear_mem();
    do_reset();
    run_instr();

    // LDA/ADD/STO/STP: 3+4 stored at 0x12, halts with PC=4.
    clear_mem();
    load(0, 16'h0010); load(1, 16'h2011); load(2, 16'h1012); load(3, 16'h7000);
    load(16'h10, 16'h0003); load(16'h11, 16'h0004);
    do_reset();
    repeat (6) run_instr();
    chk("t2_store", mem[16'h0012], 16'h0007);
    chk("t2_pc", pc_dbg, 16'h0004);
    chk1("t2_halted", halted, 1'b1);

    // Negative result: JGE falls through, JNE taken.
    clear_mem();
    load(0, 16'h0010); load(1, 16'h3011); load(2, 16'h5020); load(3, 16'h6030);
    load(16'h10, 16'h0002); load(16'h11, 16'h0005);
    do_reset();
    repeat (4) run_instr();
    chk("t3_acc", acc_dbg, 16'hFFFD);
    chk("t3_pc", pc_dbg, 16'h0030);

    // JMP 0 loop, reset asserted mid-fetch, restart at 0.
    clear_mem();
    load(0, 16'h4000);
    do_reset();
    repeat (3) run_instr();
`ifdef MU0_SINGLE_STEP_EN
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
`endif
    chk1("t4_pre_memRq", memRq, 1'b1);
    do_reset();
    repeat (2) run_instr();

    // Undefined opcode is a bus-silent NOP.
    clear_mem();
    load(0, 16'h8ABC); load(1, 16'h0020); load(2, 16'h8FFF); load(3, 16'h7000);
    load(16'h20, 16'h1234);
    do_reset();
    run_instr();
    chk("t5_pc", pc_dbg, 16'h0001);
    chk("t5_acc", acc_dbg, 16'h0000);
    repeat (4) run_instr();
    chk("t5_acc_end", acc_dbg, 16'h1234);

    // Random programs against the interpreter.
    for (int round = 0; round < 3; round++) begin
      clear_mem();
      for (int i = 0; i < 64; i++) begin
        r_op = 4'($urandom_range(0, 15));
        if (r_op == 4'h7 && $urandom_range(0, 7) != 0) r_op = 4'h0;
        r_s = 12'($urandom_range(0, 127));
        load(i, {r_op, r_s});
      end
      for (int i = 64; i < 128; i++) load(i, 16'($urandom));
      do_reset();
      repeat (120) run_instr();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
